// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: pending latch, mask,
// fixed-priority arbitration and an ack / end-of-interrupt handshake.
module irq_controller #(
  parameter int N_IRQ = 3,
  parameter int VEC_W = 2,
  parameter logic [N_IRQ-1:0] MASK_RST = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_din,
  output logic [N_IRQ-1:0] mask_q,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vector,
  input  logic             int_ack,
  input  logic             int_eoi,
  output logic [N_IRQ-1:0] pending_q,
  output logic             in_service
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SVC  = 2'd2;

  logic [1:0]       state;
  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] edges;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] clr;
  logic [VEC_W-1:0] sel;
  logic             take_ack;

  assign edges    = irq_in & ~irq_prev;
  assign eligible = pending_q & ~mask_q;
  assign take_ack = (state == S_REQ) && int_ack;
  assign int_req    = (state == S_REQ);
  assign in_service = (state == S_SVC);

  // Lowest eligible index wins; scanning downward leaves it last.
  always_comb begin
    sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel = VEC_W'(i);
    end
  end

  // Ack clears the bit of the vector being accepted.
  always_comb begin
    clr = '0;
    if (take_ack) clr = N_IRQ'(1) << int_vector;
  end

  // Edge history, pending latch (set beats clear) and mask register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_prev  <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RST;
    end else begin
      irq_prev  <= irq_in;
      pending_q <= (pending_q & ~clr) | edges;
      if (mask_we) mask_q <= mask_din;
    end
  end

  // Request / service handshake; vector is frozen outside IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      int_vector <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|eligible) begin
            int_vector <= sel;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (int_ack) state <= S_SVC;
        end
        S_SVC: begin
          if (int_eoi) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed and random stimulus for irq_controller, checked
// against a behavioural model of the interrupt rules.
module tb_irq_controller;

  logic       clk = 0;
  logic       reset;
  logic [2:0] irq_in;
  logic       mask_we;
  logic [2:0] mask_din;
  logic [2:0] mask_q;
  logic       int_req;
  logic [1:0] int_vector;
  logic       int_ack;
  logic       int_eoi;
  logic [2:0] pending_q;
  logic       in_service;

  int checks = 0;
  int failures = 0;

  // model: mode 0 idle, 1 requesting, 2 serving
  logic [2:0] m_prev, m_pend, m_mask;
  int         m_mode;
  int         m_vec;

  irq_controller #(.N_IRQ(3), .VEC_W(2), .MASK_RST(3'b000)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in),
    .mask_we(mask_we), .mask_din(mask_din), .mask_q(mask_q),
    .int_req(int_req), .int_vector(int_vector),
    .int_ack(int_ack), .int_eoi(int_eoi),
    .pending_q(pending_q), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [2:0] e;
    logic [2:0] np;
    int         nm;
    int         nv;
    if (!reset) begin
      m_prev = 0; m_pend = 0; m_mask = 3'b000;
      m_mode = 0; m_vec = 0;
      return;
    end
    e  = irq_in & ~m_prev;
    np = m_pend;
    nm = m_mode;
    nv = m_vec;
    if (m_mode == 0) begin
      for (int i = 2; i >= 0; i--)
        if (m_pend[i] && !m_mask[i]) begin nv = i; nm = 1; end
    end else if (m_mode == 1) begin
      if (int_ack) begin np[m_vec] = 1'b0; nm = 2; end
    end else begin
      if (int_eoi) nm = 0;
    end
    m_pend = np | e;
    m_mode = nm;
    m_vec  = nv;
    if (mask_we) m_mask = mask_din;
    m_prev = irq_in;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("int_req", 8'(int_req), 8'(m_mode == 1));
    chk("in_service", 8'(in_service), 8'(m_mode == 2));
    chk("int_vector", 8'(int_vector), 8'(m_vec));
    chk("pending_q", 8'(pending_q), 8'(m_pend));
    chk("mask_q", 8'(mask_q), 8'(m_mask));
  endtask

  task automatic ack();
    int_ack = 1; cyc(); int_ack = 0;
  endtask

  task automatic eoi();
    int_eoi = 1; cyc(); int_eoi = 0;
  endtask

  initial begin
    reset = 0; irq_in = 0; mask_we = 0; mask_din = 0;
    int_ack = 0; int_eoi = 0;
    m_prev = 0; m_pend = 0; m_mask = 0; m_mode = 0; m_vec = 0;
    cyc(); cyc();
    chk("rst_req", 8'(int_req), 8'd0);
    chk("rst_pend", 8'(pending_q), 8'd0);
    reset = 1;
    cyc();

    // single pulse on line 0
    irq_in = 3'b001; cyc();
    chk("t1_pend", 8'(pending_q), 8'h1);
    irq_in = 3'b000; cyc();
    chk("t1_req", 8'(int_req), 8'd1);
    chk("t1_vec", 8'(int_vector), 8'd0);

    // ack then eoi
    ack();
    chk("t2_svc", 8'(in_service), 8'd1);
    chk("t2_pend", 8'(pending_q), 8'h0);
    eoi();
    chk("t2_idle", 8'(in_service), 8'd0);
    cyc();
    chk("t2_noreq", 8'(int_req), 8'd0);

    // simultaneous edges on lines 2 and 0
    irq_in = 3'b101; cyc();
    irq_in = 3'b000; cyc();
    chk("t3_vec0", 8'(int_vector), 8'd0);
    ack(); eoi(); cyc();
    chk("t3_req2", 8'(int_req), 8'd1);
    chk("t3_vec2", 8'(int_vector), 8'd2);
    ack(); eoi();

    // masked line latches but does not request
    mask_we = 1; mask_din = 3'b001; cyc(); mask_we = 0;
    irq_in = 3'b001; cyc();
    irq_in = 3'b000; cyc(); cyc();
    chk("t4_pend", 8'(pending_q), 8'h1);
    chk("t4_noreq", 8'(int_req), 8'd0);
    mask_we = 1; mask_din = 3'b000; cyc(); mask_we = 0;
    cyc();
    chk("t4_req", 8'(int_req), 8'd1);
    chk("t4_vec", 8'(int_vector), 8'd0);
    ack(); eoi();

    // higher priority edge while requesting vector 2
    irq_in = 3'b100; cyc();
    irq_in = 3'b000; cyc();
    irq_in = 3'b001; cyc();
    irq_in = 3'b000; cyc();
    chk("t5_hold", 8'(int_vector), 8'd2);
    chk("t5_req", 8'(int_req), 8'd1);
    ack(); eoi(); cyc();
    chk("t5_vec0", 8'(int_vector), 8'd0);
    ack();

    // reset during service
    reset = 0; cyc();
    chk("t6_svc", 8'(in_service), 8'd0);
    chk("t6_req", 8'(int_req), 8'd0);
    chk("t6_pend", 8'(pending_q), 8'h0);
    chk("t6_mask", 8'(mask_q), 8'h0);
    reset = 1;

    // random traffic
    for (int n = 0; n < 600; n++) begin
      irq_in   = 3'($urandom_range(0, 7));
      int_ack  = ($urandom_range(0, 3) == 0);
      int_eoi  = ($urandom_range(0, 3) == 0);
      mask_we  = ($urandom_range(0, 15) == 0);
      mask_din = 3'($urandom_range(0, 7));
      reset    = ($urandom_range(0, 63) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
